// File: rtl/rand_pkg.sv
// Shared types and constants for the PRBS-15 randomizer frame controller.
package rand_pkg;

    localparam int unsigned PRBS_W = 15;
    localparam logic [PRBS_W-1:0] DEFAULT_SEED = 15'h3715;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/randomizer_frame_ctrl_if.sv
// Parallel frame handshakes: frame in from framing logic, randomized frame out.
interface randomizer_frame_ctrl_if #(
    parameter int unsigned FRAME_BITS = 96
);
    logic [FRAME_BITS-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [FRAME_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/prbs15_core.sv
// Bare PRBS-15 (x^15 + x^14 + 1) bit-serial scrambler; load has priority over en.
module prbs15_core
    import rand_pkg::*;
#(
    parameter logic [PRBS_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [PRBS_W-1:0] seed,
    input  logic              in_bit,
    output logic              out_bit,
    output logic [PRBS_W-1:0] state
);

    logic [PRBS_W-1:0] state_q;
    logic              fb;

    assign fb      = state_q[0] ^ state_q[1];
    assign out_bit = in_bit ^ fb;
    assign state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= {fb, state_q[PRBS_W-1:1]};
        end
    end

endmodule

// File: rtl/randomizer_frame_ctrl.sv
// Frame-level sequencer around prbs15_core: accepts a parallel frame, scrambles it
// MSB first, and returns it in parallel; seed reloads happen only at frame start.
module randomizer_frame_ctrl
    import rand_pkg::*;
#(
    parameter int unsigned       FRAME_BITS = 96,
    parameter logic [PRBS_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   reset,
    randomizer_frame_ctrl_if.slave bus,
    input  logic [PRBS_W-1:0]      cfg_seed,
    input  logic                   cfg_seed_we,
    input  logic                   cfg_reseed_each,
    output logic                   cfg_err,
    output logic                   busy,
    output logic [15:0]            frames_done
);

    localparam int unsigned CntW = $clog2(FRAME_BITS);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] oreg_q, oreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [PRBS_W-1:0]     seed_q, seed_d;
    logic                  pending_q, pending_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [15:0]           frames_q, frames_d;

    logic                  accept;
    logic                  core_load, core_en, core_out;
    logic [PRBS_W-1:0]     lfsr_state;

    assign accept = (state_q == StIdle) && bus.in_valid && in_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (pending_q || cfg_reseed_each) ? StLoad : StRun;
            StLoad:  state_d = StRun;
            StRun:   if (cnt_q == '0) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        core_load   = (state_q == StLoad);
        core_en     = (state_q == StRun);
        shreg_d     = shreg_q;
        oreg_d      = oreg_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        pending_d   = pending_q;
        err_d       = 1'b0;
        frames_d    = frames_q;
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d != StIdle);

        if (accept) begin
            shreg_d = bus.in_data;
            cnt_d   = CntW'(FRAME_BITS - 1);
        end
        if (core_en) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            oreg_d  = {oreg_q[FRAME_BITS-2:0], core_out};
            cnt_d   = cnt_q - 1'b1;
        end
        if ((state_q == StDone) && bus.out_ready) begin
            frames_d = frames_q + 16'd1;
        end

        // A write landing on the LOAD cycle keeps pending set so it hits the next frame.
        if (core_load) pending_d = 1'b0;
        if (cfg_seed_we) begin
            if (cfg_seed != '0) begin
                seed_d    = cfg_seed;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            oreg_q      <= '0;
            cnt_q       <= '0;
            seed_q      <= SEED;
            pending_q   <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            shreg_q     <= shreg_d;
            oreg_q      <= oreg_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

    prbs15_core #(
        .SEED (SEED)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (core_load),
        .en      (core_en),
        .seed    (seed_q),
        .in_bit  (shreg_q[FRAME_BITS-1]),
        .out_bit (core_out),
        .state   (lfsr_state)
    );

    // Zero seeds are rejected, so the LFSR can never reach its lock-up state.
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (reset) lfsr_state != '0);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = oreg_q;
    assign cfg_err       = err_q;
    assign busy          = busy_q;
    assign frames_done   = frames_q;

endmodule

// File: tb/tb_randomizer_frame_ctrl.sv
// Directed bench for randomizer_frame_ctrl with a recurrence-based PRBS-15 reference.
module tb_randomizer_frame_ctrl;

    localparam logic [95:0] GOLD_IN  = 96'hACBC_D211_4DAE_1577_C6DB_F4C9;
    localparam logic [95:0] GOLD_OUT = 96'h558A_C4A5_3A17_24E1_63AC_2BF9;

    logic        clk;
    logic        reset;
    logic [14:0] cfg_seed;
    logic        cfg_seed_we;
    logic        cfg_reseed_each;
    logic        cfg_err;
    logic        busy;
    logic [15:0] frames_done;

    int n_vec;
    int n_err;
    int exp_frames;

    randomizer_frame_ctrl_if #(.FRAME_BITS(96)) bus ();

    randomizer_frame_ctrl #(
        .FRAME_BITS (96),
        .SEED       (15'h3715)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .cfg_seed        (cfg_seed),
        .cfg_seed_we     (cfg_seed_we),
        .cfg_reseed_each (cfg_reseed_each),
        .cfg_err         (cfg_err),
        .busy            (busy),
        .frames_done     (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bit sequence b[j+15] = b[j] ^ b[j+1]; keystream bit n is b[n+15].
    function automatic logic [95:0] keystream(input logic [14:0] seed, input int start);
        logic        b [0:511];
        logic [95:0] r;
        for (int j = 0; j < 15; j++) b[j] = seed[j];
        for (int j = 15; j < start + 111; j++) b[j] = b[j-15] ^ b[j-14];
        for (int n = 0; n < 96; n++) r[95-n] = b[start+n+15];
        return r;
    endfunction

    task automatic accept(input logic [95:0] d);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 96'(bus.in_ready), 96'(1));
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int act_cyc, input logic [14:0] act_seed,
                           output logic [95:0] got, output int lat);
        int cyc;
        cyc = 1;
        while (cyc < 2000) begin
            if (cyc == 1) check("busy_running", 96'(busy), 96'(1));
            if (cyc == act_cyc) begin
                cfg_seed    = act_seed;
                cfg_seed_we = 1'b1;
            end
            if (act_cyc > 0 && cyc == act_cyc + 1) begin
                cfg_seed_we = 1'b0;
                if (act_seed == '0) check("cfg_err_pulse", 96'(cfg_err), 96'(1));
            end
            if (act_cyc > 0 && act_seed == '0 && cyc == act_cyc + 2)
                check("cfg_err_single", 96'(cfg_err), 96'(0));
            if (bus.out_valid) break;
            @(negedge clk);
            cyc++;
        end
        check("out_valid_seen", 96'(bus.out_valid), 96'(1));
        lat = cyc;
        got = bus.out_data;
    endtask

    task automatic run_frame(input string tag, input logic [95:0] din, input int act_cyc,
                             input logic [14:0] act_seed, input logic [95:0] exp_data,
                             input int exp_lat);
        logic [95:0] got;
        int          lat;
        accept(din);
        collect(act_cyc, act_seed, got, lat);
        check({tag, "_data"}, got, exp_data);
        check({tag, "_latency"}, 96'(lat), 96'(exp_lat));
        if (bus.out_ready) begin
            @(negedge clk);
            exp_frames++;
            check({tag, "_frames_done"}, 96'(frames_done), 96'(exp_frames));
        end
    endtask

    initial begin
        logic [95:0] held;
        logic        bad;
        n_vec           = 0;
        n_err           = 0;
        exp_frames      = 0;
        reset           = 1'b1;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        cfg_seed        = '0;
        cfg_seed_we     = 1'b0;
        cfg_reseed_each = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 96'(bus.in_ready), 96'(0));
        check("rst_out_valid", 96'(bus.out_valid), 96'(0));
        check("rst_out_data", bus.out_data, 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_cfg_err", 96'(cfg_err), 96'(0));
        check("rst_frames_done", 96'(frames_done), 96'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 96'(bus.in_ready), 96'(1));

        // First frame after reset always reloads; the second runs on freely.
        run_frame("golden", GOLD_IN, 0, '0, GOLD_OUT, 98);
        run_frame("freerun", '0, 0, '0, keystream(15'h3715, 96), 97);

        cfg_reseed_each = 1'b1;
        run_frame("b2b_1", GOLD_IN, 0, '0, GOLD_OUT, 98);
        run_frame("b2b_2", GOLD_IN, 0, '0, GOLD_OUT, 98);

        run_frame("zero_seed_wr", GOLD_IN, 10, 15'h0000, GOLD_OUT, 98);

        bus.out_ready = 1'b0;
        run_frame("bp", GOLD_IN, 0, '0, GOLD_OUT, 98);
        held = bus.out_data;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_data !== held || bus.in_ready !== 1'b0 || !bus.out_valid ||
                frames_done !== 16'(exp_frames)) bad = 1'b1;
        end
        check("bp_hold", 96'(bad), 96'(0));
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_frames++;
        check("bp_frames_done", 96'(frames_done), 96'(exp_frames));
        check("bp_out_valid_drop", 96'(bus.out_valid), 96'(0));
        @(negedge clk);
        check("bp_single_handshake", 96'(frames_done), 96'(exp_frames));

        run_frame("seed_wr_inflight", GOLD_IN, 10, 15'h7FFF, GOLD_OUT, 98);
        cfg_reseed_each = 1'b0;
        run_frame("seed_7fff", '0, 0, '0, keystream(15'h7FFF, 0), 98);

        // Write on the LOAD cycle: this frame keeps the old seed, the next gets the new one.
        cfg_reseed_each = 1'b1;
        run_frame("wr_on_load", '0, 1, 15'h3715, keystream(15'h7FFF, 0), 98);
        cfg_reseed_each = 1'b0;
        run_frame("after_load_wr", GOLD_IN, 0, '0, GOLD_OUT, 98);

        accept(GOLD_IN);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_frames = 0;
        check("midrst_out_valid", 96'(bus.out_valid), 96'(0));
        check("midrst_busy", 96'(busy), 96'(0));
        check("midrst_frames_done", 96'(frames_done), 96'(0));
        reset = 1'b0;
        @(negedge clk);
        run_frame("post_reset", GOLD_IN, 0, '0, GOLD_OUT, 98);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
